// File: rtl/cd_tx_ser_if.sv
// rtl/cd_tx_ser_if.sv - CDBUS transmit serializer bus bundle
// Groups the byte handshake, dividers, control and line signals of cd_tx_ser.
interface cd_tx_ser_if;
   logic [15:0] div_ls;
   logic [15:0] div_hs;
   logic [7:0]  data;
   logic        data_valid;
   logic        data_ready;
   logic        send_break;
   logic        abort;
   logic        rx;
   logic        tx;
   logic        tx_en;
   logic        cd;
   logic        byte_done;

   modport master (
      output div_ls, div_hs, data, data_valid, send_break, abort, rx,
      input  data_ready, tx, tx_en, cd, byte_done
   );

   modport slave (
      input  div_ls, div_hs, data, data_valid, send_break, abort, rx,
      output data_ready, tx, tx_en, cd, byte_done
   );
endinterface

// File: rtl/cd_tx_ser.sv
// rtl/cd_tx_ser.sv - CDBUS bit serializer and line driver, transmit direction
// Start/8 data LSB first/stop framing, low-speed arbitration byte, break and abort.
module cd_tx_ser (
   input  logic       clk,
   input  logic       reset_n,
   cd_tx_ser_if.slave bus
);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_STOP  = 3'd3;
   localparam logic [2:0] S_BREAK = 3'd4;

   logic [2:0]  r_state;
   logic [15:0] r_cnt;
   logic [15:0] r_div;
   logic        r_hs_sel;
   logic [7:0]  r_shift;
   logic [3:0]  r_bit;
   logic        r_cd;
   logic        r_byte_done;

   logic        w_bit_end;
   logic        w_sample;
   logic        w_tx;
   logic        w_ready;
   logic        w_accept;
   logic        w_collide;

   // r_div holds the divider latched at bit start, so mid-bit changes wait a bit
   assign w_bit_end = (r_cnt == r_div);
   assign w_sample  = (r_cnt == (r_div >> 1));

   always_comb begin
      w_tx = 1'b1;
      case (r_state)
         S_START: w_tx = 1'b0;
         S_DATA:  w_tx = r_shift[0];
         S_BREAK: w_tx = (r_bit == 4'd10);
         default: w_tx = 1'b1;
      endcase
   end

   always_comb begin
      w_ready = 1'b0;
      if (!bus.abort) begin
         if (r_state == S_IDLE)
            w_ready = !bus.send_break;
         else if (r_state == S_STOP)
            w_ready = w_bit_end;
      end
   end

   assign w_accept  = bus.data_valid & w_ready;
   assign w_collide = !r_hs_sel && ((r_state == S_DATA) || (r_state == S_STOP))
                      && w_sample && w_tx && !bus.rx;

   assign bus.data_ready = w_ready;
   assign bus.tx         = w_tx;
   assign bus.tx_en      = (r_state != S_IDLE);
   assign bus.cd         = r_cd;
   assign bus.byte_done  = r_byte_done;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= 16'd0;
         r_div       <= 16'd0;
         r_hs_sel    <= 1'b0;
         r_shift     <= 8'd0;
         r_bit       <= 4'd0;
         r_cd        <= 1'b0;
         r_byte_done <= 1'b0;
      end else begin
         r_cd        <= 1'b0;
         r_byte_done <= 1'b0;
         if (bus.abort) begin
            r_state  <= S_IDLE;
            r_hs_sel <= 1'b0;
            r_cnt    <= 16'd0;
         end else if (w_collide) begin
            r_state  <= S_IDLE;
            r_hs_sel <= 1'b0;
            r_cnt    <= 16'd0;
            r_cd     <= 1'b1;
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_cnt <= 16'd0;
                  if (bus.send_break) begin
                     r_state  <= S_BREAK;
                     r_div    <= bus.div_ls;
                     r_bit    <= 4'd0;
                     r_hs_sel <= 1'b0;
                  end else if (w_accept) begin
                     r_state  <= S_START;
                     r_shift  <= bus.data;
                     r_div    <= bus.div_ls;
                     r_hs_sel <= 1'b0;
                  end
               end
               default: begin
                  if (!w_bit_end) begin
                     r_cnt <= r_cnt + 16'd1;
                  end else begin
                     r_cnt <= 16'd0;
                     r_div <= r_hs_sel ? bus.div_hs : bus.div_ls;
                     case (r_state)
                        S_START: begin
                           r_state <= S_DATA;
                           r_bit   <= 4'd0;
                        end
                        S_DATA: begin
                           r_shift <= r_shift >> 1;
                           if (r_bit == 4'd7)
                              r_state <= S_STOP;
                           else
                              r_bit <= r_bit + 4'd1;
                        end
                        S_STOP: begin
                           r_byte_done <= 1'b1;
                           if (w_accept) begin
                              r_state  <= S_START;
                              r_shift  <= bus.data;
                              r_hs_sel <= 1'b1;
                              r_div    <= bus.div_hs;
                           end else begin
                              r_state  <= S_IDLE;
                              r_hs_sel <= 1'b0;
                           end
                        end
                        S_BREAK: begin
                           if (r_bit == 4'd10)
                              r_state <= S_IDLE;
                           else
                              r_bit <= r_bit + 4'd1;
                        end
                        default: r_state <= S_IDLE;
                     endcase
                  end
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_cd_tx_ser.sv
// tb/tb_cd_tx_ser.sv - scoreboard bench for cd_tx_ser
// Each transmit segment is predicted from the framing rules and checked by a line monitor.
module tb_cd_tx_ser;
   logic clk;
   logic reset_n;
   cd_tx_ser_if bus ();

   cd_tx_ser u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct {
      logic [7:0]  data;
      int unsigned div;
      int          len;
      bit          brk;
      bit          cd;
      bit          done;
   } rec_t;

   rec_t exp_q[$];
   bit   cap_bits[$];
   bit   cap_on;
   int   checks;
   int   errors;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Line level of cycle i of a segment, straight from the frame definition
   function automatic bit exp_bit(input rec_t r, input int i);
      int p;
      int b;
      p = int'(r.div) + 1;
      b = i / p;
      if (r.brk) return (b >= 10);
      if (b == 0) return 1'b0;
      if (b <= 8) return r.data[b-1];
      return 1'b1;
   endfunction

   function automatic int full_len(input int unsigned div, input bit brk);
      return (brk ? 11 : 10) * (int'(div) + 1);
   endfunction

   function automatic rec_t mk(input logic [7:0] d, input int unsigned div, input int len,
                               input bit brk, input bit cdx, input bit done);
      rec_t r;
      r.data = d; r.div = div; r.len = len; r.brk = brk; r.cd = cdx; r.done = done;
      return r;
   endfunction

   always @(negedge clk) begin
      bit   closing;
      rec_t r;
      int   nbad;
      closing = cap_on && (bus.byte_done || !bus.tx_en);
      if (closing) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected_segment: got %0d cycles expected none", cap_bits.size());
         end else begin
            r = exp_q.pop_front();
            chk("seg_len", cap_bits.size(), r.len);
            nbad = 0;
            for (int i = 0; i < cap_bits.size() && i < r.len; i++)
               if (cap_bits[i] != exp_bit(r, i)) nbad++;
            chk("seg_wave_bad_cycles", nbad, 0);
            chk("seg_cd", int'(bus.cd), int'(r.cd));
            chk("seg_byte_done", int'(bus.byte_done), int'(r.done));
            if (r.cd) chk("cd_tx_idle", int'(bus.tx), 1);
         end
         cap_on = 1'b0;
      end else begin
         if (bus.cd)        chk("stray_cd", 1, 0);
         if (bus.byte_done) chk("stray_byte_done", 1, 0);
      end
      if (bus.tx_en) begin
         if (!cap_on) begin
            cap_on = 1'b1;
            cap_bits.delete();
         end
         cap_bits.push_back(bus.tx);
      end
   end

   task automatic send_byte(input logic [7:0] d);
      int n;
      @(negedge clk);
      bus.data       = d;
      bus.data_valid = 1'b1;
      n = 0;
      #1;
      while (!bus.data_ready && n < 3000) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 3000) chk("accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      bus.data_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((bus.tx_en || exp_q.size() != 0) && n < 5000) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 5000) chk("idle_timeout", 0, 1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1);
   end

   initial begin
      int nb;
      logic [7:0] d;
      checks = 0;
      errors = 0;
      cap_on = 1'b0;
      reset_n = 1'b0;
      bus.div_ls = 16'd9;
      bus.div_hs = 16'd3;
      bus.data = 8'h00;
      bus.data_valid = 1'b0;
      bus.send_break = 1'b0;
      bus.abort = 1'b0;
      bus.rx = 1'b1;
      #3;
      chk("rst_tx", int'(bus.tx), 1);
      chk("rst_tx_en", int'(bus.tx_en), 0);
      chk("rst_cd", int'(bus.cd), 0);
      chk("rst_byte_done", int'(bus.byte_done), 0);
      chk("rst_data_ready", int'(bus.data_ready), 1);
      repeat (2) @(posedge clk);
      #2 reset_n = 1'b1;

      // single byte at low speed
      exp_q.push_back(mk(8'hA5, 9, 100, 0, 0, 1));
      send_byte(8'hA5);
      wait_idle();

      // back-to-back, second byte at high speed with rx held low
      exp_q.push_back(mk(8'h01, 9, 100, 0, 0, 1));
      exp_q.push_back(mk(8'h80, 3, 40, 0, 0, 1));
      send_byte(8'h01);
      send_byte(8'h80);
      bus.rx = 1'b0;
      repeat (40) @(posedge clk);
      #1 bus.rx = 1'b1;
      wait_idle();

      // collision on data bit 2
      exp_q.push_back(mk(8'hFF, 9, 35, 0, 1, 0));
      send_byte(8'hFF);
      repeat (30) @(posedge clk);
      #1 bus.rx = 1'b0;
      repeat (10) @(posedge clk);
      #1 bus.rx = 1'b1;
      wait_idle();

      // break wins over a simultaneous byte
      bus.div_ls = 16'd4;
      exp_q.push_back(mk(8'h00, 4, 55, 1, 0, 0));
      @(negedge clk);
      bus.send_break = 1'b1;
      bus.data_valid = 1'b1;
      bus.data = 8'h77;
      #1 chk("break_data_ready", int'(bus.data_ready), 0);
      @(posedge clk);
      #1;
      bus.send_break = 1'b0;
      bus.data_valid = 1'b0;
      wait_idle();

      // abort mid-DATA
      bus.div_ls = 16'd9;
      exp_q.push_back(mk(8'h5A, 9, 46, 0, 0, 0));
      send_byte(8'h5A);
      repeat (45) @(posedge clk);
      #1 bus.abort = 1'b1;
      #1 chk("abort_data_ready", int'(bus.data_ready), 0);
      @(posedge clk);
      #1 bus.abort = 1'b0;
      wait_idle();

      // asynchronous reset mid-STOP
      exp_q.push_back(mk(8'h3C, 9, 95, 0, 0, 0));
      send_byte(8'h3C);
      repeat (95) @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_tx", int'(bus.tx), 1);
      chk("mid_rst_tx_en", int'(bus.tx_en), 0);
      chk("mid_rst_data_ready", int'(bus.data_ready), 1);
      chk("mid_rst_cd", int'(bus.cd), 0);
      chk("mid_rst_byte_done", int'(bus.byte_done), 0);
      @(negedge clk);
      @(posedge clk);
      #2 reset_n = 1'b1;
      wait_idle();

      // randomized frames
      for (int f = 0; f < 20; f++) begin
         bus.div_ls = 16'($urandom_range(1, 7));
         bus.div_hs = 16'($urandom_range(1, 4));
         nb = $urandom_range(1, 3);
         for (int b = 0; b < nb; b++) begin
            d = 8'($urandom);
            exp_q.push_back(mk(d, (b == 0) ? 32'(bus.div_ls) : 32'(bus.div_hs),
                               full_len((b == 0) ? 32'(bus.div_ls) : 32'(bus.div_hs), 0),
                               0, 0, 1));
            send_byte(d);
         end
         wait_idle();
      end

      chk("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
